// File: rtl/fsmc_reg_bank_if.sv
// FSMC register-bank bus: MCU access phases, read data, sample push and interrupt.
interface fsmc_reg_bank_if;
    logic [3:0]  cs;
    logic        addr_en;
    logic        rd_en;
    logic        wr_en;
    logic [15:0] mcu_wdata;
    logic [31:0] mcu_rdata;
    logic        sample_valid;
    logic [15:0] sample_data;
    logic        irq;

    modport master (
        output cs, addr_en, rd_en, wr_en, mcu_wdata, sample_valid, sample_data,
        input  mcu_rdata, irq
    );

    modport slave (
        input  cs, addr_en, rd_en, wr_en, mcu_wdata, sample_valid, sample_data,
        output mcu_rdata, irq
    );
endinterface

// File: rtl/fsmc_reg_bank.sv
// FSMC-facing register bank with a sample FIFO, threshold/overflow flags and a level irq.
module fsmc_reg_bank #(
    parameter int          FIFO_DEPTH = 16,
    parameter logic [15:0] BLOCK_ID   = 16'hA55A
) (
    input logic             clk,
    input logic             reset,
    fsmc_reg_bank_if.slave  bus
);
    localparam int         PTR_W     = $clog2(FIFO_DEPTH);
    localparam logic [8:0] LVL_FULL  = 9'(FIFO_DEPTH);

    // MCU phase edge detection; rst_q masks the first cycle after reset so a
    // phase already high at release is not mistaken for a fresh edge.
    logic        ae_q, rd_q, wr_q, rst_q;
    logic        ae_rise, rd_rise, wr_rise;
    logic [3:0]  sel;
    logic        vld_p1;
    logic [31:0] rdata_p2;
    logic        irq_q;

    // Control and status state
    logic        fifo_en, irq_en, clr_pend;
    logic [7:0]  thr;
    logic [15:0] scratch;
    logic        thr_flag, ovf_flag;

    // FIFO storage (data only, never reset)
    logic [15:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [8:0]       level;

    logic        empty, full;
    logic [15:0] status, head, reg_val;
    logic        push_req, pop, push, ovf_set, thr_set;
    logic        wr_ctrl, wr_scratch, wr_irq;

    assign ae_rise = bus.addr_en & ~ae_q & ~rst_q;
    assign rd_rise = bus.rd_en   & ~rd_q & ~rst_q;
    assign wr_rise = bus.wr_en   & ~wr_q & ~rst_q;

    assign empty  = (level == 9'd0);
    assign full   = (level == LVL_FULL);
    assign status = {4'b0, ovf_flag, empty, full, level};
    assign head   = empty ? 16'h0 : mem[rd_ptr];

    // A same-cycle pop frees a slot, so a push into a full FIFO still lands.
    assign push_req = bus.sample_valid & fifo_en;
    assign pop      = rd_rise & (sel == 4'd3) & ~empty;
    assign push     = push_req & (~full | pop);
    assign ovf_set  = push_req & full & ~pop & ~clr_pend;
    assign thr_set  = (thr != 8'd0) && (level >= {1'b0, thr});

    assign wr_ctrl    = wr_rise & (sel == 4'd0);
    assign wr_scratch = wr_rise & (sel == 4'd2);
    assign wr_irq     = wr_rise & (sel == 4'd5);

    assign bus.mcu_rdata = rdata_p2;
    assign bus.irq       = irq_q;

    // Register read mux addressed by the latched select
    always_comb begin
        reg_val = 16'h0;
        case (sel)
            4'd0: reg_val = {thr, 5'b0, 1'b0, irq_en, fifo_en};
            4'd1: reg_val = status;
            4'd2: reg_val = scratch;
            4'd3: reg_val = head;
            4'd4: reg_val = BLOCK_ID;
            4'd5: reg_val = {14'b0, ovf_flag, thr_flag};
            default: reg_val = 16'h0;
        endcase
    end

    // Edge detect, select latch, read-data prefetch and registered irq
    always_ff @(posedge clk) begin
        if (reset) begin
            ae_q     <= 1'b0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            rst_q    <= 1'b1;
            sel      <= 4'd0;
            vld_p1   <= 1'b0;
            rdata_p2 <= 32'h0;
            irq_q    <= 1'b0;
        end else begin
            ae_q   <= bus.addr_en;
            rd_q   <= bus.rd_en;
            wr_q   <= bus.wr_en;
            rst_q  <= 1'b0;
            vld_p1 <= ae_rise;
            if (ae_rise)
                sel <= bus.cs;
            // stage p1 -> p2: capture status and selected register
            if (vld_p1)
                rdata_p2 <= {status, reg_val};
            irq_q <= irq_en & (thr_flag | ovf_flag);
        end
    end

    // CTRL and SCRATCH writes; fifo_clr is a one-cycle pending pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            fifo_en  <= 1'b0;
            irq_en   <= 1'b0;
            clr_pend <= 1'b0;
            thr      <= 8'd0;
            scratch  <= 16'h0;
        end else begin
            clr_pend <= 1'b0;
            if (wr_ctrl) begin
                fifo_en  <= bus.mcu_wdata[0];
                irq_en   <= bus.mcu_wdata[1];
                clr_pend <= bus.mcu_wdata[2];
                thr      <= bus.mcu_wdata[15:8];
            end
            if (wr_scratch)
                scratch <= bus.mcu_wdata;
        end
    end

    // Sticky flags: write-1-to-clear, with a concurrent set taking precedence
    always_ff @(posedge clk) begin
        if (reset) begin
            thr_flag <= 1'b0;
            ovf_flag <= 1'b0;
        end else begin
            thr_flag <= thr_set | (thr_flag & ~(wr_irq & bus.mcu_wdata[0]));
            ovf_flag <= ovf_set | (ovf_flag & ~(wr_irq & bus.mcu_wdata[1]));
        end
    end

    // FIFO pointers and level; a pending clear discards that cycle's push/pop
    always_ff @(posedge clk) begin
        if (reset || clr_pend) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= 9'd0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   level <= level + 9'd1;
                2'b01:   level <= level - 9'd1;
                default: level <= level;
            endcase
        end
    end

    // FIFO storage write
    always_ff @(posedge clk) begin
        if (push && !clr_pend && !reset)
            mem[wr_ptr] <= bus.sample_data;
    end
endmodule
